// File: rtl/if_pkg.sv
// Shared types and default constants for the if_prefetch fetch stage.
package if_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int INST_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;
  localparam int INST_BYTES = INST_W_DEF / 8;

  // DROP is kept for a future multi-cycle memory where a response can trail a redirect.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_entry_t;

  function automatic int inst_bytes(input int inst_w);
    return inst_w / 8;
  endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Bus bundle for if_prefetch: redirect, memory req/ack and ID valid/ready.
// IF_ALIGN_CHECK_EN adds the fetch_fault signal.
interface if_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) ();

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [INST_W-1:0] mem_data;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] pc;
  logic              id_ready;
  logic              stall_req;
`ifdef IF_ALIGN_CHECK_EN
  logic              fetch_fault;
`endif

`ifdef IF_ALIGN_CHECK_EN
  modport master (
    input  redirect, redirect_pc, mem_ack, mem_data, id_ready,
    output mem_req, mem_addr, inst_valid, inst, pc, stall_req, fetch_fault
  );
  modport slave (
    output redirect, redirect_pc, mem_ack, mem_data, id_ready,
    input  mem_req, mem_addr, inst_valid, inst, pc, stall_req, fetch_fault
  );
`else
  modport master (
    input  redirect, redirect_pc, mem_ack, mem_data, id_ready,
    output mem_req, mem_addr, inst_valid, inst, pc, stall_req
  );
  modport slave (
    output redirect, redirect_pc, mem_ack, mem_data, id_ready,
    input  mem_req, mem_addr, inst_valid, inst, pc, stall_req
  );
`endif

endinterface

// File: rtl/if_fifo.sv
// Synchronous FIFO with clear and a registered head word (valid whenever not empty).
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] remain;
  logic [WIDTH-1:0] head_reg;
  logic             push_eff;
  logic             pop_eff;

  assign full        = (count_reg == CNT_W'(DEPTH));
  assign empty       = (count_reg == '0);
  assign push_eff    = push && (!full || pop);
  assign pop_eff     = pop && !empty;
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop_eff);
  assign remain      = count_reg - CNT_W'(pop_eff);

  always_ff @(posedge clk) begin
    if (push_eff && !clear) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // The head register is refilled from the array, or bypassed from din when the
  // incoming word becomes the new head.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_eff);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= remain + CNT_W'(push_eff);
      if (push_eff && (remain == '0)) begin
        head_reg <= din;
      end else if (pop_eff) begin
        head_reg <= mem[rd_ptr_next];
      end
    end
  end

  assign head  = head_reg;
  assign count = count_reg;

endmodule

// File: rtl/if_prefetch.sv
// Registered instruction prefetch: sequential req/ack fetch into a FIFO feeding ID.
// Build option IF_ALIGN_CHECK_EN: misaligned redirects raise fetch_fault and halt fetch.
module if_prefetch
  import if_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter int                DEPTH    = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  if_prefetch_if.master bus
);

  localparam int                STEP_BYTES = inst_bytes(INST_W);
  localparam int                CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(STEP_BYTES);
  localparam logic [ADDR_W-1:0] LOW_MASK   = ADDR_W'(STEP_BYTES - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] fetch_pc_reg;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic              stall_reg;
  logic              stall_next;
  logic              fetch_enable;

  logic              fifo_push;
  logic              fifo_pop;
  entry_t            fifo_din;
  entry_t            fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_after;
  logic              fifo_full;
  logic              fifo_empty;

`ifdef IF_ALIGN_CHECK_EN
  logic fault_reg;
  logic fault_next;
  logic redirect_misaligned;

  assign redirect_misaligned = |(bus.redirect_pc & LOW_MASK);
  assign fetch_enable        = !fault_reg;
`else
  assign fetch_enable        = 1'b1;
`endif

  assign fifo_pop      = !fifo_empty && bus.id_ready;
  assign fifo_din.pc   = fetch_pc_reg;
  assign fifo_din.inst = bus.mem_data;

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    fifo_push     = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    fault_next    = fault_reg;
`endif

    if (bus.redirect) begin
`ifdef IF_ALIGN_CHECK_EN
      fetch_pc_next = bus.redirect_pc;
      fault_next    = redirect_misaligned;
      state_next    = redirect_misaligned ? IDLE : WAIT;
`else
      fetch_pc_next = bus.redirect_pc & ~LOW_MASK;
      state_next    = WAIT;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_full && fetch_enable) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_ack) begin
            fifo_push     = 1'b1;
            fetch_pc_next = fetch_pc_reg + STEP;
          end
        end
        DROP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end

    // Occupancy after this edge; a redirect empties the FIFO regardless of push/pop.
    if (bus.redirect) begin
      count_after = '0;
    end else begin
      count_after = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end

    if (fifo_push && (count_after >= DEPTH_CNT)) begin
      state_next = IDLE;
    end

    stall_next = (count_after == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      stall_reg    <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      fault_reg    <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      stall_reg    <= stall_next;
`ifdef IF_ALIGN_CHECK_EN
      fault_reg    <= fault_next;
`endif
    end
  end

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.redirect),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.mem_req    = (state_reg == WAIT);
  assign bus.mem_addr   = fetch_pc_reg;
  assign bus.inst_valid = !fifo_empty;
  assign bus.inst       = fifo_head.inst;
  assign bus.pc         = fifo_head.pc;
  assign bus.stall_req  = stall_reg;
`ifdef IF_ALIGN_CHECK_EN
  assign bus.fetch_fault = fault_reg;
`endif

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
Parametrised instruction-fetch stage. It replaces the combinational pass-through fetch with a registered prefetch unit. It issues sequential fetch requests over a req/ack memory handshake and buffers returned instructions and their PCs in a DEPTH-entry FIFO. It presents them to ID with a valid/ready handshake and supports branch/jump redirect with flush. It sits between the PC/redirect logic of EX and the instruction memory port, and feeds ID.

Parameters:
ADDR_W, 32, instruction address width
INST_W, 32, instruction word width
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
redirect_i  in  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  in  ADDR_W  redirect target
mem_req_o  out  1  fetch request valid
mem_addr_o  out  ADDR_W  fetch address
mem_ack_i  in  1  memory accepts request and returns data this cycle
mem_data_i  in  INST_W  instruction data, valid with mem_ack_i
inst_valid_o  out  1  FIFO head valid
inst_o  out  INST_W  head instruction
pc_o  out  ADDR_W  head PC
id_ready_i  in  1  ID consumes head when inst_valid_o && id_ready_i
stall_req_o  out  1  fetch starved: FIFO empty and not in reset

Behaviour:
- Reset values (sync, rst high at posedge): mem_req_o=0, mem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, pc_o=0, stall_req_o=0, fetch_pc=RESET_PC, FIFO empty, state IDLE.
- States:
  - IDLE: no request outstanding.
  - WAIT: mem_req_o=1 held, mem_addr_o stable until mem_ack_i.
  - DROP: reserved for a pending response after redirect. It is unreachable here, because ack and data are same-cycle. The encoding is kept for multi-cycle memory.
- IDLE->WAIT when slots are free (count < DEPTH). This is registered, so mem_req_o rises the cycle after the condition holds.
- First request after reset: mem_req_o=1, addr RESET_PC, in the first cycle after rst deasserts.
- WAIT with mem_ack_i:
  - Push {fetch_pc, mem_data_i} into the FIFO.
  - Set fetch_pc += INST_W/8 (wraps modulo 2^ADDR_W).
  - If the FIFO has room after the push (count_next < DEPTH), stay in WAIT with the new address next cycle (back-to-back). Otherwise go to IDLE.
- Latency: ack at cycle N gives inst_valid_o at N+1, provided the FIFO was empty. Throughput is one instruction per cycle with continuous acks.
- Pop: inst_valid_o && id_ready_i advances the head. Simultaneous push and pop at count==DEPTH cannot occur, because a request is only issued when space exists.
- Redirect (highest priority):
  - FIFO is cleared and fetch_pc=redirect_pc_i.
  - Any same-cycle mem_ack_i data is discarded.
  - A same-cycle pop is ignored.
  - Next cycle: inst_valid_o=0, mem_req_o=1, mem_addr_o=redirect_pc_i.
  - A redirect while WAIT without ack abandons the request; the address changes next cycle. The memory tolerates a request withdrawal.
- stall_req_o is registered: 1 when the FIFO is empty after the update and rst=0. It is 0 during reset.
- rst mid-operation: overrides redirect and ack. All state returns to reset values at that edge.

Optional Feature:
IF_ALIGN_CHECK_EN
- Defined:
  - Adds output fetch_fault_o (1 bit, reset 0).
  - A redirect_pc_i with low bits not aligned to INST_W/8 sets fetch_fault_o=1 next cycle and no request is issued.
  - It stays set and fetch halts in IDLE until the next aligned redirect or rst.
- Undefined: no port; low bits are forced to zero on redirect.

Decomposition:
- Package if_pkg:
  - state enum {IDLE, WAIT, DROP}
  - INST_BYTES = INST_W/8
  - default parameter constants
  - FIFO entry struct {pc, inst}
- One sub-module if_fifo: synchronous FIFO with parameters DEPTH and WIDTH and a clear input, driven by redirect. It provides push, pop, head, count, full and empty. It has no read latency: the head is a registered output.

Test Plan:
- Reset release, mem_ack_i tied 1 -> mem_req_o=1 addr 0x0 at cycle 1. inst_valid_o at cycle 2 with pc_o 0x0, then 0x4, 0x8 on consecutive cycles.
- id_ready_i=0, ack always 1 -> exactly DEPTH=4 pushes (0x0..0xC), then mem_req_o=0. Raise ready -> one pop per cycle, fetch resumes at 0x10.
- Redirect to 0x100 with FIFO holding 3 entries and a same-cycle ack -> next cycle inst_valid_o=0, mem_addr_o=0x100. The acked data never appears at inst_o.
- Ack every third cycle, ready=1 -> stall_req_o=1 on empty cycles. Output PCs stay strictly sequential.
- fetch_pc=0xFFFFFFFC, ack -> next address 0x00000000 (wrap).
- IF_ALIGN_CHECK_EN: redirect to 0x102 -> fetch_fault_o=1, mem_req_o=0. Redirect to 0x200 -> fault clears, request 0x200. rst asserted mid-WAIT -> all outputs at reset values next cycle.
